// File: rtl/dff_pipe_if.sv
// Ready/valid handshake bundle for dff_pipe: upstream push side and downstream pop side.
// The master drives words in and consumes words out; the pipeline itself is the slave.
interface dff_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/dff_pipe.sv
// Stallable register pipeline: DEPTH stages of WIDTH-bit words with per-stage valid bits,
// bubble collapsing, synchronous flush and an occupancy count.
module dff_pipe #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              OCC_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    dff_pipe_if.slave        bus,
    output logic [OCC_W-1:0] occupancy
);

    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;

    // A stage may load when it, or any stage after it, is empty, or when the
    // last stage is draining; this is the unrolled form of the backward ready chain.
    always_comb begin
        logic all_full;
        adv      = '0;
        all_full = 1'b1;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            all_full = all_full & v[i];
            adv[i]   = !all_full | bus.out_ready;
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(v[i]);
        end
    end

    assign bus.in_ready  = adv[0] & !flush;
    assign bus.out_valid = v[DEPTH-1];
    assign bus.out_data  = data[DEPTH-1];

    // Flush clears only the valid bits; data registers keep their contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data[i] <= RESET_VAL;
            end
        end else if (flush) begin
            v <= '0;
        end else begin
            if (adv[0]) begin
                data[0] <= bus.in_data;
                v[0]    <= bus.in_valid;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (adv[i]) begin
                    data[i] <= data[i-1];
                    v[i]    <= v[i-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_dff_pipe.sv
// Directed bench for dff_pipe: a DEPTH=3 instance for reset, streaming, stall, bubble,
// flush and reset-priority cases, plus a DEPTH=1 instance under alternating back-pressure.
module tb_dff_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush_a;
    logic       flush_b;
    logic [1:0] occ_a;
    logic [0:0] occ_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dff_pipe_if #(.WIDTH(8)) bus_a ();
    dff_pipe_if #(.WIDTH(8)) bus_b ();

    dff_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) dut_a (
        .clk(clk), .rst(rst), .flush(flush_a), .bus(bus_a), .occupancy(occ_a)
    );

    dff_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) dut_b (
        .clk(clk), .rst(rst), .flush(flush_b), .bus(bus_b), .occupancy(occ_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Drives the DEPTH=3 instance for the coming edge and lets combinational outputs settle.
    task automatic applyStimulus(input logic vld, input logic [7:0] din, input logic ordy, input logic fl);
        bus_a.in_valid  = vld;
        bus_a.in_data   = din;
        bus_a.out_ready = ordy;
        flush_a         = fl;
        #1;
    endtask

    initial begin
        logic       mv;
        logic [7:0] mdata;
        logic [7:0] next_in;
        logic [7:0] next_out;
        logic       ordy;
        logic       exp_ready;

        rst = 1'b1;
        flush_b = 1'b0;
        bus_b.in_valid = 1'b1;
        bus_b.in_data = 8'hAA;
        bus_b.out_ready = 1'b0;
        applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
        nextCycle();
        nextCycle();
        rst = 1'b0;
        bus_b.in_valid = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("reset_out_valid", 32'(bus_a.out_valid), 0);
        checkOutput("reset_out_data", 32'(bus_a.out_data), 32'h00);
        checkOutput("reset_occupancy", 32'(occ_a), 0);
        checkOutput("reset_in_ready", 32'(bus_a.in_ready), 1);
        checkOutput("reset_b_out_valid", 32'(bus_b.out_valid), 0);

        // Streaming: word j accepted at edge j+1 is visible after edge j+3.
        for (int j = 0; j < 9; j++) begin
            applyStimulus(j < 5, 8'(8'h01 + j), 1'b1, 1'b0);
            checkOutput("stream_in_ready", 32'(bus_a.in_ready), 1);
            checkOutput("stream_out_valid", 32'(bus_a.out_valid), 32'(j >= 3 && j < 8));
            if (j >= 3 && j < 8) checkOutput("stream_out_data", 32'(bus_a.out_data), 32'(j - 2));
            if (j >= 3 && j < 6) checkOutput("stream_occupancy", 32'(occ_a), 3);
            nextCycle();
        end

        // Back-pressure: three words fill the pipe, the fourth waits for out_ready.
        for (int b = 0; b < 4; b++) begin
            applyStimulus(1'b1, 8'(8'h10 + b), 1'b0, 1'b0);
            checkOutput("bp_in_ready", 32'(bus_a.in_ready), 32'(b < 3));
            nextCycle();
        end
        applyStimulus(1'b1, 8'h13, 1'b0, 1'b0);
        checkOutput("bp_full_occupancy", 32'(occ_a), 3);
        checkOutput("bp_full_out_data", 32'(bus_a.out_data), 32'h10);
        applyStimulus(1'b1, 8'h13, 1'b1, 1'b0);
        checkOutput("bp_release_in_ready", 32'(bus_a.in_ready), 1);
        checkOutput("bp_release_out_data", 32'(bus_a.out_data), 32'h10);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("bp_push_pop_occupancy", 32'(occ_a), 3);
        for (int b = 1; b < 4; b++) begin
            checkOutput("bp_drain_out_valid", 32'(bus_a.out_valid), 1);
            checkOutput("bp_drain_out_data", 32'(bus_a.out_data), 32'(8'h10 + b));
            nextCycle();
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checkOutput("bp_empty_out_valid", 32'(bus_a.out_valid), 0);
        checkOutput("bp_empty_occupancy", 32'(occ_a), 0);

        // Bubble collapse while stalled.
        applyStimulus(1'b1, 8'h20, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        nextCycle();
        nextCycle();
        applyStimulus(1'b1, 8'h21, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("bubble_occupancy", 32'(occ_a), 2);
        checkOutput("bubble_out_data", 32'(bus_a.out_data), 32'h20);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("bubble_first_valid", 32'(bus_a.out_valid), 1);
        checkOutput("bubble_first_data", 32'(bus_a.out_data), 32'h20);
        nextCycle();
        checkOutput("bubble_second_valid", 32'(bus_a.out_valid), 1);
        checkOutput("bubble_second_data", 32'(bus_a.out_data), 32'h21);
        nextCycle();
        checkOutput("bubble_done_valid", 32'(bus_a.out_valid), 0);

        // Flush a full pipe while a new word is offered.
        for (int f = 0; f < 3; f++) begin
            applyStimulus(1'b1, 8'(8'h30 + f), 1'b0, 1'b0);
            nextCycle();
        end
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b1);
        checkOutput("flush_in_ready", 32'(bus_a.in_ready), 0);
        checkOutput("flush_out_valid_visible", 32'(bus_a.out_valid), 1);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("flush_out_valid", 32'(bus_a.out_valid), 0);
        checkOutput("flush_occupancy", 32'(occ_a), 0);
        checkOutput("flush_data_kept", 32'(bus_a.out_data), 32'h30);
        for (int f = 0; f < 4; f++) begin
            nextCycle();
            checkOutput("flush_no_leak", 32'(bus_a.out_valid), 0);
        end

        // Reset wins over flush and a pending push; data returns to RESET_VAL.
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
        nextCycle();
        nextCycle();
        nextCycle();
        checkOutput("prerst_out_data", 32'(bus_a.out_data), 32'h55);
        rst = 1'b1;
        applyStimulus(1'b1, 8'h66, 1'b0, 1'b1);
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("midrst_out_data", 32'(bus_a.out_data), 32'h00);
        checkOutput("midrst_occupancy", 32'(occ_a), 0);
        checkOutput("midrst_in_ready", 32'(bus_a.in_ready), 1);

        // Single-stage build: continuous pushes with out_ready toggling every cycle.
        mv       = 1'b0;
        mdata    = 8'h00;
        next_in  = 8'h40;
        next_out = 8'h40;
        for (int k = 0; k < 10; k++) begin
            ordy = (k % 2) == 1;
            bus_b.in_valid  = 1'b1;
            bus_b.in_data   = next_in;
            bus_b.out_ready = ordy;
            #1;
            exp_ready = !mv | ordy;
            checkOutput("d1_in_ready", 32'(bus_b.in_ready), 32'(exp_ready));
            checkOutput("d1_out_valid", 32'(bus_b.out_valid), 32'(mv));
            if (mv) checkOutput("d1_out_data", 32'(bus_b.out_data), 32'(mdata));
            if (mv && ordy) begin
                checkOutput("d1_order", 32'(bus_b.out_data), 32'(next_out));
                next_out = next_out + 8'h01;
            end
            if (exp_ready) begin
                mv      = 1'b1;
                mdata   = next_in;
                next_in = next_in + 8'h01;
            end
            nextCycle();
        end
        checkOutput("d1_occupancy", 32'(occ_b), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dff_pipe.md
# dff_pipe

Parametrised register pipeline with per-stage valid tracking and a ready/valid handshake at both ends; the multi-bit, multi-stage successor to the single-bit D flip-flop. Carries WIDTH-bit words through DEPTH register stages. Supports back-pressure, bubble collapsing, synchronous flush and an occupancy count. Used wherever a datapath needs fixed-latency retiming that can also stall without losing data.

## Interface
- WIDTH, 8, data word width in bits (>= 1)
- DEPTH, 3, number of register stages (>= 1)
- RESET_VAL, 0, value loaded into every data stage on reset
- OCC_W, $clog2(DEPTH+1), width of occupancy output (derived; not overridden)

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- flush  input  1  synchronous clear of all stage valid bits
- in_valid  input  1  upstream word present on in_data
- in_ready  output  1  stage 0 can accept this cycle
- in_data  input  WIDTH  upstream word
- out_valid  output  1  last stage holds a valid word
- out_ready  input  1  downstream accepts this cycle
- out_data  output  WIDTH  last-stage data register
- occupancy  output  OCC_W  number of stages currently valid (0..DEPTH)

## Operation
- State: data[i] (WIDTH bits) and v[i] (1 bit) for i = 0..DEPTH-1; stage DEPTH-1 drives out_data/out_valid directly (registered outputs, no combinational path from in_data).
- Advance enable, computed from the last stage backward: adv[DEPTH-1] = !v[DEPTH-1] | out_ready; adv[i] = !v[i] | adv[i+1].
- in_ready = adv[0] & !flush.
- On a rising edge with rst = 0 and flush = 0, for each stage i with adv[i] = 1:
  - i = 0: data[0] <= in_data, v[0] <= in_valid.
  - i > 0: data[i] <= data[i-1], v[i] <= v[i-1].
- Stages with adv[i] = 0 hold data and valid unchanged.
- Bubble collapsing: an invalid stage always accepts, so gaps close while the output is stalled.
- data[i] of an invalid stage is don't-care but is still loaded per the rule above (no extra gating).
- Input handshake: a word transfers when in_valid & in_ready. Output handshake: a word transfers when out_valid & out_ready.
- flush = 1: on the next edge all v[i] <= 0. Data registers are unchanged. The in_data word that cycle is not accepted, because in_ready = 0. out_valid remains visible during the flush cycle itself, and downstream may still complete that transfer.
- rst = 1: on the next edge all v[i] <= 0 and all data[i] <= RESET_VAL. rst has priority over flush and over the handshake.
- occupancy = popcount(v), combinational from registered valid bits.
- Order is strictly preserved; no word is duplicated or dropped except by flush or rst.
- DEPTH = 1: degenerates to a single registered stage, with in_ready = !out_valid | out_ready.

## Timing
- Reset values after the rst edge: out_valid = 0, out_data = RESET_VAL, occupancy = 0, in_ready = 1 (when flush = 0).
- Latency: a word accepted at edge N appears with out_valid = 1 after edge N+DEPTH-1, provided out_ready held 1 and no stall.
  - i.e. DEPTH cycles from in_valid sampled to out_valid asserted.
- Throughput: one word per cycle when out_ready = 1 continuously.
- Full stall: with all DEPTH stages valid and out_ready = 0, in_ready = 0. When out_ready rises, in_ready = 1 in the same cycle (combinational ready chain, depth DEPTH).
- Simultaneous push and pop when full: accepted; occupancy unchanged.
- Mid-operation reset or flush: takes effect at the next edge regardless of handshake state. Any pending input is dropped.

## Test plan
- Reset: hold rst 2 cycles with in_valid = 1, in_data = 8'hAA -> out_valid = 0, out_data = 8'h00, occupancy = 0 after release; in_ready = 1.
- Streaming (WIDTH = 8, DEPTH = 3): out_ready = 1; push 8'h01..8'h05 on consecutive cycles -> out_data 01..05 on consecutive cycles, first at 3 cycles after the first push; occupancy steady at 3.
- Back-pressure: out_ready = 0; push 8'h10, 8'h11, 8'h12, 8'h13 -> first three accepted, in_ready = 0 on the 4th, occupancy = 3. Raise out_ready -> outputs 10, 11, 12, 13 in order, with 13 accepted the cycle out_ready rises.
- Bubble collapse: push 8'h20, idle 2 cycles, push 8'h21, with out_ready = 0 -> occupancy = 2. Release -> 20 then 21 on back-to-back cycles.
- Flush: pipe holds 30, 31, 32; assert flush 1 cycle with in_valid = 1, in_data = 8'h33 -> in_ready = 0 that cycle; next cycle out_valid = 0, occupancy = 0; 33 never emerges.
- DEPTH = 1 build: alternate out_ready 1/0 with continuous pushes -> no loss or duplication; 1-cycle latency; in_ready = !out_valid | out_ready.
